// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of one SDRAM controller port, with read-tag FIFO steering returns.
// Define ARB_M0_PRIORITY_EN for fixed m0 priority; default build is round robin bounded by HOLD_MAX.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int HOLD_MAX = 4,
    parameter int MAX_PEND = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [ADDR_W-1:0]            i_m0_address,
    input  logic                         i_m0_read,
    input  logic                         i_m0_write,
    input  logic [31:0]                  i_m0_writedata,
    input  logic [3:0]                   i_m0_byteenable,
    output logic                         o_m0_waitrequest,
    output logic [31:0]                  o_m0_readdata,
    output logic                         o_m0_readdatavalid,
    input  logic [ADDR_W-1:0]            i_m1_address,
    input  logic                         i_m1_read,
    input  logic                         i_m1_write,
    input  logic [31:0]                  i_m1_writedata,
    input  logic [3:0]                   i_m1_byteenable,
    output logic                         o_m1_waitrequest,
    output logic [31:0]                  o_m1_readdata,
    output logic                         o_m1_readdatavalid,
    output logic [ADDR_W-1:0]            o_s_address,
    output logic                         o_s_read,
    output logic                         o_s_write,
    output logic [31:0]                  o_s_writedata,
    output logic [3:0]                   o_s_byteenable,
    input  logic                         i_s_waitrequest,
    input  logic [31:0]                  i_s_readdata,
    input  logic                         i_s_readdatavalid,
    output logic [$clog2(MAX_PEND):0]    o_pend_cnt,
    output logic                         o_err_rdv
);
    localparam int PTR_W  = $clog2(MAX_PEND);
    localparam int PEND_W = PTR_W + 1;
    localparam int CNT_W  = $clog2(HOLD_MAX + 1);

    // state | meaning
    // IDLE  | no grant, nothing forwarded
    // GNT0  | m0 owns the controller port
    // GNT1  | m1 owns the controller port
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_tag [MAX_PEND];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [PEND_W-1:0]  r_pend;
    logic               r_err;

    logic w_own, w_granted, w_req0, w_req1, w_own_req, w_oth_req;
    logic w_own_rd, w_own_wr, w_full, w_empty, w_rd_block;
    logic w_accept, w_push, w_pop, w_hold_done, w_win, w_yield;

    always_comb begin
        w_own      = (r_state == GNT1);
        w_granted  = (r_state != IDLE);
        w_req0     = i_m0_read | i_m0_write;
        w_req1     = i_m1_read | i_m1_write;
        w_own_req  = w_own ? w_req1 : w_req0;
        w_oth_req  = w_own ? w_req0 : w_req1;
        w_own_rd   = w_own ? i_m1_read  : i_m0_read;
        w_own_wr   = w_own ? i_m1_write : i_m0_write;
        w_full     = (r_pend == PEND_W'(MAX_PEND));
        w_empty    = (r_pend == '0);
        w_rd_block = w_full & w_own_rd;

        o_s_address    = w_own ? i_m1_address    : i_m0_address;
        o_s_writedata  = w_own ? i_m1_writedata  : i_m0_writedata;
        o_s_byteenable = w_own ? i_m1_byteenable : i_m0_byteenable;
        o_s_read       = w_granted & w_own_rd & ~w_full;
        o_s_write      = w_granted & w_own_wr;

        o_m0_waitrequest = (r_state != GNT0) | i_s_waitrequest | w_rd_block;
        o_m1_waitrequest = (r_state != GNT1) | i_s_waitrequest | w_rd_block;

        w_accept = (o_s_read | o_s_write) & ~i_s_waitrequest;
        w_push   = w_accept & o_s_read;
        w_pop    = i_s_readdatavalid & ~w_empty;

        o_m0_readdatavalid = w_pop & ~r_tag[r_rptr];
        o_m1_readdatavalid = w_pop &  r_tag[r_rptr];
        o_m0_readdata      = i_s_readdata;
        o_m1_readdata      = i_s_readdata;
        o_pend_cnt         = r_pend;
        o_err_rdv          = r_err;
    end

    always_comb begin
        w_hold_done = (int'(r_cnt) + 1 == HOLD_MAX);
`ifdef ARB_M0_PRIORITY_EN
        w_win   = ~w_req0;
        w_yield = w_own & w_req0;
`else
        w_win   = (w_req0 & w_req1) ? ~r_last : w_req1;
        w_yield = w_hold_done & w_oth_req;
`endif
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_req0 | w_req1) begin
                    w_state_nxt = w_win ? GNT1 : GNT0;
                    w_last_nxt  = w_win;
                end
            end
            GNT0, GNT1: begin
                // a stalled command keeps the owner; switching only happens at accept or idle owner
                if (w_accept) begin
                    w_cnt_nxt = w_hold_done ? '0 : r_cnt + CNT_W'(1);
                    if (w_yield) begin
                        w_state_nxt = w_own ? GNT0 : GNT1;
                        w_last_nxt  = ~w_own;
                        w_cnt_nxt   = '0;
                    end
                end else if (!w_own_req) begin
                    w_cnt_nxt = '0;
                    if (w_oth_req) begin
                        w_state_nxt = w_own ? GNT0 : GNT1;
                        w_last_nxt  = ~w_own;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_pend <= r_pend + PEND_W'(1);
                2'b01:   r_pend <= r_pend - PEND_W'(1);
                default: r_pend <= r_pend;
            endcase
            if (i_s_readdatavalid & w_empty) r_err <= 1'b1;
        end
    end

    // tag storage needs no reset: entries are only read between push and pop
    always_ff @(posedge i_clk) begin
        if (w_push) r_tag[r_wptr] <= w_own;
    end
endmodule
